// File: rtl/tpg_multi.sv
// Programmable video test-pattern generator: runtime timing captured once per frame,
// pixel-enable gated counters, four patterns, frame markers and a completed-frame counter.
module tpg_multi #(
    parameter int PW      = 8,
    parameter int H_BITS  = 12,
    parameter int V_BITS  = 12,
    parameter int FC_BITS = 8,
    parameter int HS_POL  = 1,
    parameter int VS_POL  = 1,
    parameter int CK_LOG  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                anim,
    input  logic [3*PW-1:0]     solid_rgb,
    input  logic [H_BITS-1:0]   tBAR_W,
    input  logic [H_BITS-1:0]   tHS_START,
    input  logic [H_BITS-1:0]   tHS_END,
    input  logic [H_BITS-1:0]   tHACT_START,
    input  logic [H_BITS-1:0]   tHACT_END,
    input  logic [H_BITS-1:0]   tH_END,
    input  logic [V_BITS-1:0]   tVS_START,
    input  logic [V_BITS-1:0]   tVS_END,
    input  logic [V_BITS-1:0]   tVACT_START,
    input  logic [V_BITS-1:0]   tVACT_END,
    input  logic [V_BITS-1:0]   tV_END,
    output logic                hs,
    output logic                vs,
    output logic                vld,
    output logic [3*PW-1:0]     rgb,
    output logic                sof,
    output logic                eol,
    output logic [FC_BITS-1:0]  frame_cnt
);

    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    typedef struct packed {
        logic [1:0]        mode;
        logic              anim;
        logic [3*PW-1:0]   solid;
        logic [H_BITS-1:0] bar_w;
        logic [H_BITS-1:0] hs_s;
        logic [H_BITS-1:0] hs_e;
        logic [H_BITS-1:0] ha_s;
        logic [H_BITS-1:0] ha_e;
        logic [H_BITS-1:0] h_end;
        logic [V_BITS-1:0] vs_s;
        logic [V_BITS-1:0] vs_e;
        logic [V_BITS-1:0] va_s;
        logic [V_BITS-1:0] va_e;
        logic [V_BITS-1:0] v_end;
    } cfg_t;

    function automatic logic [3*PW-1:0] bar_colour(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        return {{PW{c[2]}}, {PW{c[1]}}, {PW{c[0]}}};
    endfunction

    cfg_t               live, cfg, shd_q, shd_d;
    logic [H_BITS-1:0]  h_q, h_d, x;
    logic [V_BITS-1:0]  v_q, v_d, y;
    logic [FC_BITS-1:0] fc_q, fc_d;
    logic [H_BITS-1:0]  bar_cnt_q, bar_cnt_d, cur_cnt, nxt_cnt, bar_w_eff;
    logic [2:0]         bar_idx_q, bar_idx_d, cur_idx;
    logic               hs_q, hs_d, vs_q, vs_d, vld_q, vld_d, sof_q, sof_d, eol_q, eol_d;
    logic [3*PW-1:0]    rgb_q, rgb_d, pix;
    logic               origin, hsync, vsync, act, ck;

    assign live = {mode, anim, solid_rgb, tBAR_W, tHS_START, tHS_END, tHACT_START,
                   tHACT_END, tH_END, tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END};

    always_comb begin
        shd_d     = shd_q;
        h_d       = h_q;
        v_d       = v_q;
        fc_d      = fc_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        vld_d     = vld_q;
        sof_d     = sof_q;
        eol_d     = eol_q;
        rgb_d     = rgb_q;

        // The frame-origin cycle decodes with live inputs; everything after uses the snapshot.
        origin = (h_q == '0) && (v_q == '0);
        cfg    = origin ? live : shd_q;

        hsync = (h_q >= cfg.hs_s) && (h_q < cfg.hs_e);
        vsync = (v_q >= cfg.vs_s) && (v_q < cfg.vs_e);
        act   = (h_q >= cfg.ha_s) && (h_q < cfg.ha_e) &&
                (v_q >= cfg.va_s) && (v_q < cfg.va_e);
        x     = h_q - cfg.ha_s;
        y     = v_q - cfg.va_s;

        bar_w_eff = (cfg.bar_w == '0) ? H_BITS'(1) : cfg.bar_w;
        cur_cnt   = (x == '0) ? '0 : bar_cnt_q;
        cur_idx   = (x == '0) ? 3'd0 : bar_idx_q;
        nxt_cnt   = cur_cnt + H_BITS'(1);
        ck        = x[CK_LOG] ^ y[CK_LOG] ^ (cfg.anim & fc_q[0]);

        case (cfg.mode)
            2'd0:    pix = cfg.solid;
            2'd1:    pix = bar_colour(cur_idx);
            2'd2:    pix = {3{x[PW-1:0]}};
            default: pix = {(3*PW){ck}};
        endcase

        if (en) begin
            if (origin) begin
                shd_d = live;
            end
            hs_d  = hsync ? HS_ACT : ~HS_ACT;
            vs_d  = vsync ? VS_ACT : ~VS_ACT;
            vld_d = act;
            sof_d = act && (x == '0) && (y == '0);
            eol_d = act && ((h_q + H_BITS'(1)) == cfg.ha_e);
            rgb_d = act ? pix : '0;

            if (act) begin
                if (nxt_cnt == bar_w_eff) begin
                    bar_cnt_d = '0;
                    bar_idx_d = (cur_idx == 3'd7) ? 3'd7 : cur_idx + 3'd1;
                end else begin
                    bar_cnt_d = nxt_cnt;
                    bar_idx_d = cur_idx;
                end
            end

            if (h_q >= cfg.h_end) begin
                h_d = '0;
                if (v_q >= cfg.v_end) begin
                    v_d  = '0;
                    fc_d = fc_q + FC_BITS'(1);
                end else begin
                    v_d = v_q + V_BITS'(1);
                end
            end else begin
                h_d = h_q + H_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            fc_q      <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            hs_q      <= ~HS_ACT;
            vs_q      <= ~VS_ACT;
            vld_q     <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            rgb_q     <= '0;
        end else begin
            shd_q     <= shd_d;
            h_q       <= h_d;
            v_q       <= v_d;
            fc_q      <= fc_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            vld_q     <= vld_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            rgb_q     <= rgb_d;
        end
    end

    assign hs        = hs_q;
    assign vs        = vs_q;
    assign vld       = vld_q;
    assign rgb       = rgb_q;
    assign sof       = sof_q;
    assign eol       = eol_q;
    assign frame_cnt = fc_q;

endmodule

// File: tb/tb_tpg_multi.sv
// Bench for tpg_multi: directed frames plus randomized timing/config, every cycle compared
// against a frame-level reference model built from the pattern rules.
module tb_tpg_multi;

    localparam int PW = 8, H_BITS = 12, V_BITS = 12, FC_BITS = 8, CK_LOG = 3;
    localparam int HS_POL = 0, VS_POL = 1;
    localparam logic HSA = (HS_POL != 0);
    localparam logic VSA = (VS_POL != 0);

    logic clk, rst_n, en, anim;
    logic [1:0] mode;
    logic [3*PW-1:0] solid_rgb;
    logic [H_BITS-1:0] tBAR_W, tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [V_BITS-1:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
    logic hs, vs, vld, sof, eol;
    logic [3*PW-1:0] rgb;
    logic [FC_BITS-1:0] frame_cnt;

    tpg_multi #(.PW(PW), .H_BITS(H_BITS), .V_BITS(V_BITS), .FC_BITS(FC_BITS),
                .HS_POL(HS_POL), .VS_POL(VS_POL), .CK_LOG(CK_LOG)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .anim(anim), .solid_rgb(solid_rgb),
        .tBAR_W(tBAR_W), .tHS_START(tHS_START), .tHS_END(tHS_END),
        .tHACT_START(tHACT_START), .tHACT_END(tHACT_END), .tH_END(tH_END),
        .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
        .tVACT_END(tVACT_END), .tV_END(tV_END),
        .hs(hs), .vs(vs), .vld(vld), .rgb(rgb), .sof(sof), .eol(eol), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int mode, anim, solid, bar_w;
        int hs_s, hs_e, ha_s, ha_e, h_end;
        int vs_s, vs_e, va_s, va_e, v_end;
    } mcfg_t;

    logic [23:0] bars [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                              24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};

    mcfg_t msh;
    int mh, mv, mfc;
    logic e_hs, e_vs, e_vld, e_sof, e_eol;
    logic [23:0] e_rgb;
    int e_fc;

    function automatic mcfg_t live_cfg();
        mcfg_t c;
        c.mode = int'(mode); c.anim = int'(anim); c.solid = int'(solid_rgb); c.bar_w = int'(tBAR_W);
        c.hs_s = int'(tHS_START); c.hs_e = int'(tHS_END); c.ha_s = int'(tHACT_START);
        c.ha_e = int'(tHACT_END); c.h_end = int'(tH_END);
        c.vs_s = int'(tVS_START); c.vs_e = int'(tVS_END); c.va_s = int'(tVACT_START);
        c.va_e = int'(tVACT_END); c.v_end = int'(tV_END);
        return c;
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; mfc = 0;
        msh = '{default: 0};
        e_hs = ~HSA; e_vs = ~VSA; e_vld = 0; e_sof = 0; e_eol = 0; e_rgb = '0; e_fc = 0;
    endtask

    task automatic model_step();
        mcfg_t c;
        int x, y, idx, bw;
        bit act, ckb;
        if (mh == 0 && mv == 0) msh = live_cfg();
        c = msh;
        e_hs = (c.hs_s <= mh && mh < c.hs_e) ? HSA : ~HSA;
        e_vs = (c.vs_s <= mv && mv < c.vs_e) ? VSA : ~VSA;
        act  = (c.ha_s <= mh && mh < c.ha_e && c.va_s <= mv && mv < c.va_e);
        x = mh - c.ha_s;
        y = mv - c.va_s;
        e_vld = act;
        e_sof = act && x == 0 && y == 0;
        e_eol = act && mh == c.ha_e - 1;
        e_rgb = '0;
        if (act) begin
            case (c.mode)
                0: e_rgb = 24'(c.solid);
                1: begin
                    bw  = (c.bar_w == 0) ? 1 : c.bar_w;
                    idx = x / bw;
                    if (idx > 7) idx = 7;
                    e_rgb = bars[idx];
                end
                2: e_rgb = 24'((x % 256) * 32'h010101);
                default: begin
                    ckb = (((x >> CK_LOG) & 1) ^ ((y >> CK_LOG) & 1) ^ (c.anim & (mfc & 1))) != 0;
                    e_rgb = ckb ? 24'hffffff : 24'h000000;
                end
            endcase
        end
        if (mh >= c.h_end) begin
            mh = 0;
            if (mv >= c.v_end) begin
                mv = 0;
                mfc++;
            end else mv++;
        end else mh++;
        e_fc = mfc % 256;
    endtask

    // ---------------- stimulus helpers ----------------
    int cnt_vld, cnt_sof, cnt_eol;
    logic [23:0] pq[$];

    task automatic cmp();
        chk("sync", 32'({hs, vs}), 32'({e_hs, e_vs}));
        chk("flags", 32'({vld, sof, eol}), 32'({e_vld, e_sof, e_eol}));
        chk("rgb", 32'(rgb), 32'(e_rgb));
        chk("frame_cnt", 32'(frame_cnt), 32'(e_fc));
    endtask

    task automatic cyc(input logic e);
        en = e;
        @(posedge clk);
        if (e) model_step();
        @(negedge clk);
        cmp();
        cnt_vld += int'(vld);
        cnt_sof += int'(sof);
        cnt_eol += int'(eol);
        if (e && vld) pq.push_back(rgb);
    endtask

    // pattern: 0 always enabled, 1 alternating 1/0, 2 random
    task automatic run(input int n, input int pat);
        for (int i = 0; i < n; i++) begin
            if (pat == 0) cyc(1'b1);
            else if (pat == 1) cyc((i % 2) == 0);
            else cyc($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic clr();
        cnt_vld = 0; cnt_sof = 0; cnt_eol = 0;
        pq.delete();
    endtask

    task automatic pulse_reset(input int lead);
        #(lead);
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp();
        #29;
        cmp();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_std();
        tHS_START = 10; tHS_END = 20; tHACT_START = 40; tHACT_END = 50; tH_END = 60;
        tVS_START = 11; tVS_END = 21; tVACT_START = 25; tVACT_END = 35; tV_END = 40;
    endtask

    task automatic set_rand();
        int he, ve;
        he = $urandom_range(0, 20);
        ve = $urandom_range(0, 12);
        tH_END = H_BITS'(he); tV_END = V_BITS'(ve);
        tHS_START = H_BITS'($urandom_range(0, he + 2)); tHS_END = H_BITS'($urandom_range(0, he + 2));
        tHACT_START = H_BITS'($urandom_range(0, he + 2)); tHACT_END = H_BITS'($urandom_range(0, he + 2));
        tVS_START = V_BITS'($urandom_range(0, ve + 2)); tVS_END = V_BITS'($urandom_range(0, ve + 2));
        tVACT_START = V_BITS'($urandom_range(0, ve + 2)); tVACT_END = V_BITS'($urandom_range(0, ve + 2));
        mode = 2'($urandom_range(0, 3));
        anim = 1'($urandom_range(0, 1));
        solid_rgb = 24'($urandom);
        tBAR_W = H_BITS'($urandom_range(0, 4));
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0;
        set_std();
        mode = 2'd2; anim = 1'b0; solid_rgb = 24'h123456; tBAR_W = 1;
        model_reset();
        clr();

        // standard timing, ramp, continuous enable
        pulse_reset(2);
        clr();
        run(2501, 0);
        chk("t1_vld_px", cnt_vld, 100);
        chk("t1_sof", cnt_sof, 1);
        chk("t1_eol", cnt_eol, 10);
        chk("t1_first_px", 32'(pq[0]), 32'h000000);
        chk("t1_last_px", 32'(pq[9]), 32'h090909);
        chk("t1_frame_cnt", 32'(frame_cnt), 1);

        // same timing, enable toggling: each output value held two cycles
        pulse_reset(0);
        clr();
        run(5002, 1);
        chk("t2_vld_cyc", cnt_vld, 200);
        chk("t2_frame_cnt", 32'(frame_cnt), 1);

        // colour bars, one pixel per bar
        mode = 2'd1; tBAR_W = 1;
        pulse_reset(0);
        clr();
        run(2501, 0);
        for (int i = 0; i < 10; i++)
            chk($sformatf("t3_bar%0d", i), 32'(pq[i]), 32'(bars[(i > 7) ? 7 : i]));

        // animated checkerboard over two frames
        mode = 2'd3; anim = 1'b1;
        pulse_reset(0);
        clr();
        run(5002, 0);
        chk("t4_f0_px0", 32'(pq[0]), 32'h000000);
        chk("t4_f0_px8", 32'(pq[8]), 32'hffffff);
        chk("t4_f1_px0", 32'(pq[100]), 32'hffffff);
        chk("t4_f1_px8", 32'(pq[108]), 32'h000000);

        // active end changed mid-frame takes effect next frame
        mode = 2'd2; anim = 1'b0;
        pulse_reset(0);
        clr();
        run(1800, 0);
        tHACT_END = 45;
        run(701, 0);
        chk("t5_f0_vld", cnt_vld, 100);
        chk("t5_f0_sof", cnt_sof, 1);
        clr();
        run(2501, 0);
        chk("t5_f1_vld", cnt_vld, 50);
        chk("t5_f1_sof", cnt_sof, 1);
        chk("t5_f1_eol", cnt_eol, 10);
        tHACT_END = 50;

        // asynchronous reset mid-line, then a clean restart
        run(1000, 0);
        pulse_reset(3);
        clr();
        run(2501, 0);
        chk("t6_frame_cnt", 32'(frame_cnt), 1);
        chk("t6_vld", cnt_vld, 100);

        // randomized timing, configuration and enable
        for (int s = 0; s < 20; s++) begin
            set_rand();
            run(700, 2);
        end
        pulse_reset(0);
        run(200, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
